// File: rtl/lsu_ctrl.sv
// Load/store control: byte mask, word address and lane-aligned data for the data memory; extends load results.
// Latency: store 2 cycles and load 3 cycles from acceptance to done. Busy holds the core until then; a missing load valid ends in timeout_err.
// Build option LSU_MISALIGN_TRAP_EN traps misaligned half/word accesses instead of issuing them.
module lsu_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_en,
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [31:0]       addr,
  input  logic [31:0]       store_data,
  output logic              request,
  output logic              we_re,
  output logic              load,
  output logic [3:0]        mask,
  output logic [ADDR_W-1:0] address,
  output logic [31:0]       data_in,
  input  logic              valid,
  input  logic [31:0]       data_out,
  output logic              busy,
  output logic              done,
  output logic [31:0]       load_data,
  output logic              misaligned,
  output logic              timeout_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t      state;
  logic        st_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [7:0]  cnt;
  logic [3:0]  acc_mask;
  logic [31:0] acc_data;
  logic        mis;
  logic [7:0]  lb;
  logic [15:0] lh;
  logic [31:0] ext;
  logic        unused_addr_hi;

  assign busy           = (state != IDLE);
  assign unused_addr_hi = ^addr[31:ADDR_W+2];

  always_comb begin
    acc_mask = 4'b1111;
    acc_data = store_data;
    case (funct3[1:0])
      2'b00: begin
        acc_mask = 4'b0001 << addr[1:0];
        acc_data = {4{store_data[7:0]}};
      end
      2'b01: begin
        acc_mask = addr[1] ? 4'b1100 : 4'b0011;
        acc_data = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign mis = ((funct3[1:0] == 2'b01) && addr[0]) ||
               (funct3[1] && (addr[1:0] != 2'b00));
`else
  assign mis = 1'b0;
`endif

  // Lane selection uses the byte offset captured at acceptance.
  assign lb = data_out[8*off_q +: 8];
  assign lh = off_q[1] ? data_out[31:16] : data_out[15:0];

  always_comb begin
    ext = data_out;
    case (f3_q)
      3'b000:  ext = {{24{lb[7]}}, lb};
      3'b001:  ext = {{16{lh[15]}}, lh};
      3'b100:  ext = {24'b0, lb};
      3'b101:  ext = {16'b0, lh};
      default: ext = data_out;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      request     <= 1'b0;
      we_re       <= 1'b0;
      load        <= 1'b0;
      done        <= 1'b0;
      misaligned  <= 1'b0;
      timeout_err <= 1'b0;
      mask        <= '0;
      address     <= '0;
      data_in     <= '0;
      load_data   <= '0;
      cnt         <= '0;
      st_q        <= 1'b0;
      f3_q        <= '0;
      off_q       <= '0;
    end else begin
      done        <= 1'b0;
      misaligned  <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_en) begin
            if (mis) begin
              misaligned <= 1'b1;
              done       <= 1'b1;
            end else begin
              mask    <= acc_mask;
              address <= addr[ADDR_W+1:2];
              data_in <= acc_data;
              we_re   <= is_store;
              request <= 1'b1;
              load    <= !is_store;
              st_q    <= is_store;
              f3_q    <= funct3;
              off_q   <= addr[1:0];
              state   <= ISSUE;
            end
          end
        end
        ISSUE: begin
          request <= 1'b0;
          load    <= 1'b0;
          we_re   <= 1'b0;
          if (st_q) begin
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            cnt   <= '0;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (valid) begin
            load_data <= ext;
            done      <= 1'b1;
            state     <= IDLE;
          end else if (cnt == 8'(TIMEOUT - 1)) begin
            // cnt holds completed WAIT cycles minus one, so this fires after TIMEOUT cycles.
            timeout_err <= 1'b1;
            done        <= 1'b1;
            state       <= IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Randomized self-checking bench for lsu_ctrl with an arithmetic reference model and a cycle-stepped memory stub.
module tb_lsu_ctrl;
  localparam int AW = 8;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_en, is_store, valid;
  logic [2:0]    funct3;
  logic [31:0]   addr, store_data, data_out;
  logic          request, we_re, load, busy, done, misaligned, timeout_err;
  logic [3:0]    mask;
  logic [AW-1:0] address;
  logic [31:0]   data_in, load_data;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] model_ld;

  lsu_ctrl #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .mem_en(mem_en), .is_store(is_store), .funct3(funct3),
    .addr(addr), .store_data(store_data), .request(request), .we_re(we_re),
    .load(load), .mask(mask), .address(address), .data_in(data_in),
    .valid(valid), .data_out(data_out), .busy(busy), .done(done),
    .load_data(load_data), .misaligned(misaligned), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] exp_mask(input logic [2:0] f3, input logic [31:0] a);
    int b;
    b = int'(a[1:0]);
    if (f3[1:0] == 2'b00) return 4'(1 << b);
    if (f3[1:0] == 2'b01) return (b >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] sd);
    if (f3[1:0] == 2'b00) return sd[7:0] * 32'h01010101;
    if (f3[1:0] == 2'b01) return sd[15:0] * 32'h00010001;
    return sd;
  endfunction

  function automatic logic [31:0] exp_ld(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] bsh, hsh;
    bsh = d >> (8 * int'(a[1:0]));
    hsh = d >> (16 * int'(a[1]));
    case (f3)
      3'd0:    return 32'($signed(bsh[7:0]));
      3'd1:    return 32'($signed(hsh[15:0]));
      3'd4:    return {24'd0, bsh[7:0]};
      3'd5:    return {16'd0, hsh[15:0]};
      default: return d;
    endcase
  endfunction

  function automatic bit exp_mis(input logic [2:0] f3, input logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
    return ((f3[1:0] == 2'b01) && a[0]) || (f3[1] && (a[1:0] != 2'b00));
`else
    return 1'b0;
`endif
  endfunction

  // Called and returns on a negedge; the next call may start on the done cycle (back-to-back).
  task automatic txn(input bit st, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] sd, input logic [31:0] d, input bit respond);
    int n;
    bit seen;
    mem_en = 1'b1; is_store = st; funct3 = f3; addr = a; store_data = sd;
    @(posedge clk); @(negedge clk);
    mem_en = 1'b0;
    if (exp_mis(f3, a)) begin
      chk("trap_misaligned", 32'(misaligned), 32'd1);
      chk("trap_done", 32'(done), 32'd1);
      chk("trap_request", 32'(request), 32'd0);
      chk("trap_busy", 32'(busy), 32'd0);
      return;
    end
    chk("misaligned", 32'(misaligned), 32'd0);
    chk("request", 32'(request), 32'd1);
    chk("we_re", 32'(we_re), 32'(st));
    chk("load", 32'(load), 32'(!st));
    chk("mask", 32'(mask), 32'(exp_mask(f3, a)));
    chk("address", 32'(address), (a >> 2) & 32'hFF);
    chk("data_in", data_in, exp_wdata(f3, sd));
    chk("busy_issue", 32'(busy), 32'd1);
    chk("done_issue", 32'(done), 32'd0);
    mem_en = 1'($urandom_range(0, 1)); is_store = 1'($urandom_range(0, 1));
    @(posedge clk); @(negedge clk);
    if (st) begin
      mem_en = 1'b0;
      chk("st_done", 32'(done), 32'd1);
      chk("st_busy", 32'(busy), 32'd0);
      chk("st_request", 32'(request), 32'd0);
      return;
    end
    chk("ld_wait_busy", 32'(busy), 32'd1);
    chk("ld_wait_load", 32'(load), 32'd0);
    chk("ld_wait_done", 32'(done), 32'd0);
    valid = respond; data_out = d; mem_en = 1'($urandom_range(0, 1));
    if (respond) begin
      @(posedge clk); @(negedge clk);
      valid = 1'b0; mem_en = 1'b0; data_out = $urandom;
      model_ld = exp_ld(f3, a, d);
      chk("ld_done", 32'(done), 32'd1);
      chk("ld_timeout", 32'(timeout_err), 32'd0);
      chk("load_data", load_data, model_ld);
    end else begin
      n = 0; seen = 1'b0;
      repeat (TO + 10) begin
        @(posedge clk); n++; @(negedge clk);
        if (done) begin seen = 1'b1; break; end
        mem_en = 1'($urandom_range(0, 1)); data_out = $urandom;
      end
      mem_en = 1'b0;
      chk("to_seen", 32'(seen), 32'd1);
      chk("to_cycles", 32'(n), 32'(TO));
      chk("to_err", 32'(timeout_err), 32'd1);
      chk("to_load_data", load_data, model_ld);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; mem_en = 1'b0; is_store = 1'b0; funct3 = '0; addr = '0;
    store_data = '0; valid = 1'b0; data_out = '0; model_ld = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_outs", {26'd0, request, we_re, load, done, misaligned, timeout_err}, 32'd0);
    chk("rst_mask_addr", {20'd0, mask, address}, 32'd0);
    chk("rst_data", data_in | load_data, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    txn(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0, 1'b1);
    txn(1'b1, 3'd0, 32'h23, 32'h000000A5, 32'h0, 1'b1);
    txn(1'b0, 3'd0, 32'h01, 32'h0, 32'h00008000, 1'b1);
    txn(1'b0, 3'd4, 32'h01, 32'h0, 32'h00008000, 1'b1);
    txn(1'b0, 3'd1, 32'h02, 32'h0, 32'h80000000, 1'b1);
    txn(1'b0, 3'd2, 32'h04, 32'h0, 32'h12345678, 1'b0);
    txn(1'b0, 3'd2, 32'h06, 32'h0, 32'hCAFEF00D, 1'b1);

    // Abort a load in WAIT: reset clears everything and produces no done.
    mem_en = 1'b1; is_store = 1'b0; funct3 = 3'd2; addr = 32'h40;
    @(posedge clk); @(negedge clk); mem_en = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("pre_abort_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_outs", {26'd0, request, we_re, load, done, misaligned, timeout_err}, 32'd0);
    chk("abort_mask_addr", {20'd0, mask, address}, 32'd0);
    chk("abort_data_in", data_in, 32'd0);
    chk("abort_load_data", load_data, 32'd0);
    model_ld = '0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    chk("post_abort_done", 32'(done), 32'd0);
    txn(1'b0, 3'd5, 32'h42, 32'h0, 32'h9ABC1234, 1'b1);

    for (int i = 0; i < 300; i++) begin
      txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
          $urandom, ($urandom_range(0, 9) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
